// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Programmable clock-enable generator. Divides clk by a ratio loaded at
//   start and emits a one-cycle tick strobe, in either periodic or one-shot
//   mode. The tick is intended as the increment enable of a downstream
//   counter.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset, overrides all other inputs
//   start      level-sampled, starts a run while IDLE
//   stop       level-sampled, aborts a run (wins over start and terminal)
//   mode       0 = periodic, 1 = one-shot, latched at start
//   div_value  divide ratio N, latched at start (0 treated as 1)
//   tick       one-cycle strobe every N_eff cycles while running
//   busy       high while in RUN
//   done       one-cycle pulse when a one-shot run completes
//   div_count  current prescale count, 0..N_eff-1
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | counting div_count 0..N_eff-1, tick on each wrap
// DONE  | one-shot finished; single cycle with done=1, then IDLE

module tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] div_value,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] div_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [DIV_W-1:0] n_eff;
  logic             mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_count <= '0;
      n_eff     <= '0;
      mode_q    <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          div_count <= '0;
          if (start && !stop) begin
            state  <= RUN;
            busy   <= 1'b1;
            mode_q <= mode;
            n_eff  <= (div_value == '0) ? ONE : div_value;
          end
        end
        RUN: begin
          if (stop) begin
            // abort beats the terminal count: no tick on this edge
            state     <= IDLE;
            busy      <= 1'b0;
            div_count <= '0;
          end else if (div_count == n_eff - ONE) begin
            div_count <= '0;
            tick      <= 1'b1;
            if (mode_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            div_count <= div_count + ONE;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          div_count <= '0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          div_count <= '0;
        end
      endcase
    end
  end

endmodule
